// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
// FIFO controller for a 16x8 single-port RAM with synchronous write and
// asynchronous read. Each cycle the RAM is used for exactly one access: a
// refill read into the registered output stage or a producer write. The
// refill read always wins. Capacity is the RAM depth plus the output register.
module ram_fifo_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [ADDR_W:0]   level,
   output logic              full,
   output logic              empty
);

   localparam int              DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic [DATA_W-1:0] data_p1;
   logic              vld_p1;
   logic              need_read;
   logic              push;

   // Slot arbitration: refill the output register whenever it is (or is about
   // to become) free and the RAM holds data; otherwise offer the slot to the
   // producer. in_ready is gated by rst_n so nothing is accepted in reset.
   always_comb begin
      need_read = (count != '0) && (!vld_p1 || out_ready);
      in_ready  = !need_read && (count != CNT_MAX) && rst_n;
      ram_addr  = need_read ? rd_ptr : wr_ptr;
      ram_we    = in_valid && in_ready;
      ram_din   = in_data;
      push      = ram_we;
   end

   // Pointer and RAM occupancy bookkeeping; read and write slots are exclusive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (need_read) begin
         rd_ptr <= rd_ptr + PTR_ONE;
         count  <= count - CNT_ONE;
      end else if (push) begin
         wr_ptr <= wr_ptr + PTR_ONE;
         count  <= count + CNT_ONE;
      end
   end

   // Stage p1: one-entry output register, loaded from the async RAM read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_p1 <= '0;
         vld_p1  <= 1'b0;
      end else if (need_read) begin
         data_p1 <= ram_dout;
         vld_p1  <= 1'b1;
      end else if (vld_p1 && out_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   // Status derived from registers only.
   always_comb begin
      out_data  = data_p1;
      out_valid = vld_p1;
      level     = count + {{ADDR_W{1'b0}}, vld_p1};
      full      = (count == CNT_MAX);
      empty     = (level == '0);
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl
// Scoreboard bench for ram_fifo_ctrl with a behavioural 16x8 RAM attached.
module tb_ram_fifo_ctrl;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;

   logic              clk;
   logic              rst_n;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic              ram_we;
   logic [DATA_W-1:0] ram_dout;
   logic [ADDR_W:0]   level;
   logic              full;
   logic              empty;

   logic [DATA_W-1:0] mem [16];
   int                wr0_cnt = 0;
   logic [DATA_W-1:0] exp_q [$];
   int                n_checks = 0;
   int                n_fail = 0;
   logic              prod_done;

   ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
      .level(level), .full(full), .empty(empty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM model: synchronous write, asynchronous read; also counts writes to address 0
   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr] <= ram_din;
         if (ram_addr == '0) wr0_cnt <= wr0_cnt + 1;
      end
   end
   assign ram_dout = mem[ram_addr];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every output handshake is compared against the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) check("unexpected_pop", int'(out_data), -1);
         else check("pop_data", int'(out_data), int'(exp_q.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DATA_W-1:0] d, output int cyc);
      logic acc;
      in_valid = 1'b1;
      in_data  = d;
      cyc      = 0;
      acc      = 1'b0;
      do begin
         @(negedge clk);
         acc = in_ready;
         tick();
         cyc++;
      end while (!acc && cyc < 50);
      if (!acc) check("push_timeout", 0, 1);
      else exp_q.push_back(d);
      in_valid = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (empty) break;
      end
      check(name, int'(empty), 1);
      check({name, "_leftover"}, exp_q.size(), 0);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int total;
      int acc_n;
      int nxt;
      int w0;
      logic [DATA_W-1:0] t1 [5];
      t1 = '{8'd55, 8'd99, 8'd150, 8'd200, 8'd77};

      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h11;
      out_ready = 1'b0;
      prod_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_level", int'(level), 0);
      check("rst_empty", int'(empty), 1);
      check("rst_full", int'(full), 0);
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_ram_we", int'(ram_we), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      tick();

      // Five pushes with consumer stalled, then drain
      total = 0;
      for (int i = 0; i < 5; i++) begin
         push(t1[i], c);
         total += c;
      end
      check("t1_push_cycles", total, 6);
      check("t1_level", int'(level), 5);
      check("t1_out_data", int'(out_data), 55);
      check("t1_out_valid", int'(out_valid), 1);
      out_ready = 1'b1;
      wait_empty("t1_empty");
      out_ready = 1'b0;

      // Fill to capacity with continuous in_valid
      acc_n    = 0;
      in_valid = 1'b1;
      for (int k = 0; k < 40; k++) begin
         in_data = 8'(acc_n);
         @(negedge clk);
         if (in_ready) acc_n++;
         tick();
      end
      check("t2_accepted", acc_n, 17);
      check("t2_full", int'(full), 1);
      check("t2_level", int'(level), 17);
      check("t2_in_ready", int'(in_ready), 0);
      check("t2_ram_we", int'(ram_we), 0);
      in_valid = 1'b0;
      for (int i = 0; i < 17; i++) exp_q.push_back(8'(i));
      out_ready = 1'b1;
      wait_empty("t2_empty");
      out_ready = 1'b0;

      // Wrap-around with random consumer stalls
      w0        = wr0_cnt;
      prod_done = 1'b0;
      fork
         begin
            int pc;
            for (int i = 0; i < 40; i++) push(8'(i), pc);
            prod_done = 1'b1;
         end
         begin
            for (int k = 0; k < 600; k++) begin
               out_ready = 1'($urandom_range(0, 1));
               tick();
               if (prod_done && empty) break;
            end
         end
      join
      out_ready = 1'b0;
      check("t3_empty", int'(empty), 1);
      check("t3_leftover", exp_q.size(), 0);
      check("t3_wraps", int'((wr0_cnt - w0) >= 2), 1);
      tick();

      // Steady concurrent push/pop around level 3
      push(8'd100, c);
      push(8'd101, c);
      push(8'd102, c);
      check("t4_level_start", int'(level), 3);
      nxt      = 103;
      in_valid = 1'b1;
      for (int k = 0; k < 16; k++) begin
         out_ready = (k % 2 == 0);
         in_data   = 8'(nxt);
         @(negedge clk);
         check("t4_level_range", int'(level >= 2 && level <= 4), 1);
         check("t4_slot", int'(ram_we), int'(!out_ready));
         if (in_ready) begin
            exp_q.push_back(8'(nxt));
            nxt++;
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_empty("t4_empty");

      // Single word, immediate pop
      push(8'hA5, c);
      check("t5_valid_before", int'(out_valid), 0);
      tick();
      check("t5_valid_rise", int'(out_valid), 1);
      check("t5_data", int'(out_data), 8'hA5);
      tick();
      check("t5_valid_fall", int'(out_valid), 0);
      check("t5_empty", int'(empty), 1);
      check("t5_leftover", exp_q.size(), 0);
      out_ready = 1'b0;

      // Reset in the middle of a fill
      for (int i = 0; i < 9; i++) push(8'(8'h10 + i), c);
      check("t6_level_pre", int'(level), 9);
      in_valid = 1'b1;
      in_data  = 8'hEE;
      rst_n    = 1'b0;
      #1;
      check("t6_out_valid", int'(out_valid), 0);
      check("t6_level", int'(level), 0);
      check("t6_full", int'(full), 0);
      check("t6_empty", int'(empty), 1);
      check("t6_in_ready", int'(in_ready), 0);
      check("t6_ram_we", int'(ram_we), 0);
      check("t6_out_data", int'(out_data), 0);
      #2;
      exp_q.delete();
      in_valid = 1'b0;
      rst_n    = 1'b1;
      tick();
      out_ready = 1'b1;
      push(8'h3C, c);
      check("t6_valid_before", int'(out_valid), 0);
      tick();
      check("t6_valid_rise", int'(out_valid), 1);
      check("t6_first_out", int'(out_data), 8'h3C);
      wait_empty("t6_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
